// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, the issue-stage busy marking
// and hazard-check ports, and the registered write port toward the register file.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  // Requester A (ALU writeback)
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  // Requester B (load writeback)
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  // Issue-stage scoreboard access
  logic              set_valid;
  logic [ADDR_W-1:0] set_addr;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;

  // Register-file write port and status
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              err_sticky;

  // Pipeline side: drives requests, observes grants and results
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output set_valid, set_addr, chk_addr1, chk_addr2,
    input  a_ready, b_ready, chk_busy1, chk_busy2,
    input  rf_we, rf_waddr, rf_wdata, err_sticky
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  set_valid, set_addr, chk_addr1, chk_addr2,
    output a_ready, b_ready, chk_busy1, chk_busy2,
    output rf_we, rf_waddr, rf_wdata, err_sticky
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with busy-bit scoreboard.
// Two writeback requesters share one registered write port; contention is
// resolved by a 1-bit round-robin pointer. A per-register busy bit is set by
// the issue stage and cleared once the write to that register is presented.
// Writes to register 0 are accepted but never performed.
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic          clk,
  input logic          rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int NumRegs = 2 ** ADDR_W;

  // Round-robin pointer: 0 favours A, 1 favours B
  logic ptr_q;
  logic ptr_d;

  logic              contested;
  logic              grant_a;
  logic              grant_b;
  logic              grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  logic err_q;
  logic err_d;

  // Grant decode; reset masks both readies so nothing transfers during reset
  always_comb begin
    contested  = bus.a_valid && bus.b_valid;
    grant_a    = !rst && bus.a_valid && (!bus.b_valid || !ptr_q);
    grant_b    = !rst && bus.b_valid && (!bus.a_valid || ptr_q);
    grant      = grant_a || grant_b;
    grant_addr = grant_b ? bus.b_addr : bus.a_addr;
    grant_data = grant_b ? bus.b_data : bus.a_data;
  end

  // Pointer moves only when both requesters competed, to the loser
  always_comb begin
    ptr_d = ptr_q;
    if (contested && !rst) begin
      ptr_d = grant_a;
    end
  end

  // Scoreboard next state: clear for the write being presented, then set;
  // applying the set last makes it win a same-address collision
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (bus.set_valid && (bus.set_addr != '0)) begin
      busy_d[bus.set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky error: a real write landed on a register nobody marked busy
  always_comb begin
    err_d = err_q;
    if (grant && (grant_addr != '0) && !busy_q[grant_addr]) begin
      err_d = 1'b1;
    end
  end

  // Arbitration pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Registered write port; addr/data hold across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant && (grant_addr != '0);
      if (grant) begin
        rf_waddr_q <= grant_addr;
        rf_wdata_q <= grant_data;
      end
    end
  end

  // Busy bits and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Hazard reads come straight from the register, no same-cycle bypass
  assign bus.chk_busy1  = busy_q[bus.chk_addr1];
  assign bus.chk_busy2  = busy_q[bus.chk_addr2];

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a table of per-cycle stimulus with expected readies,
// a queue of expected register-file writes, and a small busy/error model.
module tb_rf_wb_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit            do_rst;
    bit            av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    bit            bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    bit            sv;
    logic [AW-1:0] sa;
    logic [AW-1:0] c1;
    logic [AW-1:0] c2;
    bit            ea;
    bit            eb;
  } vec_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  int checks = 0;
  int errors = 0;

  bit [NR-1:0]   m_busy;
  bit            m_err;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  function automatic void add(bit r, bit av, int aa, int ad, bit bv, int ba, int bd,
                              bit sv, int sa, int c1, int c2, bit ea, bit eb);
    vec_t v;
    v.do_rst = r;
    v.av = av; v.aa = aa[AW-1:0]; v.ad = ad[DW-1:0];
    v.bv = bv; v.ba = ba[AW-1:0]; v.bd = bd[DW-1:0];
    v.sv = sv; v.sa = sa[AW-1:0];
    v.c1 = c1[AW-1:0]; v.c2 = c2[AW-1:0];
    v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    wr_t z;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.a_valid   = 1'b1; bus.a_addr = '0; bus.a_data = 16'h5555;
    bus.b_valid   = 1'b1; bus.b_addr = '0; bus.b_data = 16'hAAAA;
    bus.set_valid = 1'b1; bus.set_addr = 4'd9;
    bus.chk_addr1 = 4'd3; bus.chk_addr2 = 4'd9;
    @(negedge clk);
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("rst_chk_busy1", 32'(bus.chk_busy1), 32'd0);
    chk("rst_chk_busy2", 32'(bus.chk_busy2), 32'd0);
    chk("rst_err", 32'(bus.err_sticky), 32'd0);
    sb.delete();
    z.we = 1'b0; z.addr = '0; z.data = '0;
    sb.push_back(z);
    m_busy = '0; m_err = 1'b0; last_addr = '0; last_data = '0;
  endtask

  task automatic step(input vec_t v, input int idx);
    wr_t           cur;
    wr_t           nxt;
    bit            g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    if (v.do_rst) do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.a_valid   = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
    bus.b_valid   = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
    bus.set_valid = v.sv; bus.set_addr = v.sa;
    bus.chk_addr1 = v.c1; bus.chk_addr2 = v.c2;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty row=%0d actual=empty expected=entry", idx);
      cur.we = 1'b0; cur.addr = '0; cur.data = '0;
    end else begin
      cur = sb.pop_front();
      chk($sformatf("rf_we[%0d]", idx), 32'(bus.rf_we), 32'(cur.we));
      chk($sformatf("rf_waddr[%0d]", idx), 32'(bus.rf_waddr), 32'(cur.addr));
      chk($sformatf("rf_wdata[%0d]", idx), 32'(bus.rf_wdata), 32'(cur.data));
    end
    chk($sformatf("chk_busy1[%0d]", idx), 32'(bus.chk_busy1), 32'(m_busy[v.c1]));
    chk($sformatf("chk_busy2[%0d]", idx), 32'(bus.chk_busy2), 32'(m_busy[v.c2]));
    chk($sformatf("err[%0d]", idx), 32'(bus.err_sticky), 32'(m_err));
    chk($sformatf("a_ready[%0d]", idx), 32'(bus.a_ready), 32'(v.ea));
    chk($sformatf("b_ready[%0d]", idx), 32'(bus.b_ready), 32'(v.eb));
    // Model the edge that ends this cycle
    g  = v.ea || v.eb;
    ga = v.ea ? v.aa : v.ba;
    gd = v.ea ? v.ad : v.bd;
    if (g) begin
      if ((ga != '0) && !m_busy[ga]) m_err = 1'b1;
      last_addr = ga;
      last_data = gd;
      nxt.we = (ga != '0);
    end else begin
      nxt.we = 1'b0;
    end
    nxt.addr = last_addr;
    nxt.data = last_data;
    sb.push_back(nxt);
    if (cur.we) m_busy[cur.addr] = 1'b0;
    if (v.sv && (v.sa != '0)) m_busy[v.sa] = 1'b1;
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.set_valid = 1'b0; bus.set_addr = '0;
    bus.chk_addr1 = '0; bus.chk_addr2 = '0;

    //   rst av aa ad       bv ba bd       sv sa c1 c2 ea eb
    // Single A write to r5, busy visible through the write cycle
    add(1, 0, 0, 0,       0, 0, 0,       1, 5, 5, 0, 0, 0);
    add(0, 1, 5, 'h1234,  0, 0, 0,       0, 0, 5, 0, 1, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 5, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 5, 0, 0, 0);
    // Contention A,B,A,B with re-marks colliding with clears
    add(0, 0, 0, 0,       0, 0, 0,       1, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       1, 2, 1, 2, 0, 0);
    add(0, 1, 1, 'hA001,  1, 2, 'hB002,  0, 0, 1, 2, 1, 0);
    add(0, 1, 1, 'hA011,  1, 2, 'hB012,  1, 1, 1, 2, 0, 1);
    add(0, 1, 1, 'hA021,  1, 2, 'hB022,  1, 2, 1, 2, 1, 0);
    add(0, 1, 1, 'hA031,  1, 2, 'hB032,  0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 1, 2, 0, 0);
    // Address 0 writes, pointer stable across uncontested grants
    add(0, 0, 0, 0,       1, 0, 'hFFFF,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 'h0A0A,  1, 0, 'h0B0B,  0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 'h0C0C,  0, 0, 0,       0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 'h0D0D,  1, 0, 'h0E0E,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0);
    // r3: set during its own write cycle keeps it busy
    add(0, 0, 0, 0,       0, 0, 0,       1, 3, 3, 0, 0, 0);
    add(0, 1, 3, 'h3333,  0, 0, 0,       0, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0,       0, 0, 0,       1, 3, 3, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 3, 0, 0, 0);
    // Write to never-marked r7 raises the sticky error
    add(0, 1, 7, 'h7777,  0, 0, 0,       0, 0, 7, 0, 1, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 7, 0, 0, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 7, 0, 0, 0);
    // Contested stream, reset mid-stream, pointer back to A
    add(0, 1, 0, 'h1111,  1, 0, 'h2222,  0, 0, 3, 0, 1, 0);
    add(0, 1, 0, 'h1112,  1, 0, 'h2223,  0, 0, 3, 0, 0, 1);
    add(0, 1, 0, 'h1113,  1, 0, 'h2224,  0, 0, 3, 0, 1, 0);
    add(1, 1, 0, 'h1114,  1, 0, 'h2225,  0, 0, 3, 9, 1, 0);
    add(0, 0, 0, 0,       0, 0, 0,       0, 0, 3, 9, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
